// File: rtl/vga_timing_driver_pkg.sv
// vga_pkg: shared raster constants and types for the VGA timing driver.
//   - Default 640x480@60 timing (porches, sync widths, derived totals).
//   - Coordinate and colour widths plus matching typedefs.
//   - SYNC_ACTIVE: level driven on hsync/vsync during the sync pulse.
//   - in_window(): inclusive range test on a counter value.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int COLOR_W = 4;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525

    localparam logic SYNC_ACTIVE = 1'b0;

    // True when lo <= cnt <= hi.
    function automatic logic in_window(coord_t cnt, coord_t lo, coord_t hi);
        return (cnt >= lo) && (cnt <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_driver_if.sv
// vga_timing_driver_if: coordinate/colour bus between the timing driver and
// the combinational pattern generator.
//   x, y              : current raster coordinate (driven by the timing driver)
//   red, green, blue  : pattern colour for (x, y) (driven by the pattern side)
// Modports: master = timing driver, slave = pattern generator.
interface vga_timing_driver_if;

    vga_pkg::coord_t x;
    vga_pkg::coord_t y;
    vga_pkg::color_t red;
    vga_pkg::color_t green;
    vga_pkg::color_t blue;

    modport master (output x, y, input red, green, blue);
    modport slave  (input x, y, output red, green, blue);

endinterface

// File: rtl/vga_timing_driver_pixel_counter.sv
// vga_pixel_counter: pixel-rate divider plus horizontal/vertical raster counters.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   h_cnt, v_cnt: current pixel column / line, advance once per pixel period
//   pix_tick    : high on the last system clock of each pixel period
//   frame_wrap  : high on the pix_tick that wraps (H_TOTAL-1, V_TOTAL-1) -> (0, 0)
module vga_pixel_counter
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,   // 1..16
    parameter int H_TOT   = H_TOTAL,
    parameter int V_TOT   = V_TOTAL
) (
    input  logic   clk,
    input  logic   rst_n,
    output coord_t h_cnt,
    output coord_t v_cnt,
    output logic   pix_tick,
    output logic   frame_wrap
);

    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    localparam coord_t     H_LAST    = coord_t'(H_TOT - 1);
    localparam coord_t     V_LAST    = coord_t'(V_TOT - 1);
    localparam coord_t     COORD_ONE = coord_t'(1);

    logic [3:0] div_reg, div_next;
    coord_t     h_cnt_reg, h_cnt_next;
    coord_t     v_cnt_reg, v_cnt_next;
    logic       h_wrap, v_wrap;

    // With CLK_DIV=1 DIV_LAST is 0 and div_reg never leaves 0, so the tick
    // is permanently high.
    assign pix_tick   = (div_reg == DIV_LAST);
    assign h_wrap     = (h_cnt_reg == H_LAST);
    assign v_wrap     = (v_cnt_reg == V_LAST);
    assign frame_wrap = pix_tick && h_wrap && v_wrap;

    always_comb begin
        div_next   = div_reg + 4'd1;
        h_cnt_next = h_cnt_reg;
        v_cnt_next = v_cnt_reg;
        if (pix_tick) begin
            div_next = '0;
            if (h_wrap) begin
                h_cnt_next = '0;
                v_cnt_next = v_wrap ? '0 : v_cnt_reg + COORD_ONE;
            end else begin
                h_cnt_next = h_cnt_reg + COORD_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg   <= '0;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            div_reg   <= div_next;
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    assign h_cnt = h_cnt_reg;
    assign v_cnt = v_cnt_reg;

endmodule

// File: rtl/vga_timing_driver.sv
// vga_timing_driver: 640x480@60 raster timing and VGA pin driver.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   pat (master)        : x/y out to the pattern generator, red/green/blue back
//   vga_r/vga_g/vga_b   : registered, blanked colour to the connector
//   hsync, vsync        : registered active-low syncs, aligned with the colour
//   video_on            : high while the pins carry an active pixel
//   pix_tick            : one-clk pulse per pixel period
//   frame_start         : one-clk pulse after the raster wraps to (0,0)
// The pins always show the pixel that was presented on x/y during the
// previous pixel period, so colour and sync share one pixel of latency.
module vga_timing_driver
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_timing_driver_if.master  pat,
    output color_t               vga_r,
    output color_t               vga_g,
    output color_t               vga_b,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic                 pix_tick,
    output logic                 frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t HS_FIRST = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_LAST  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_FIRST = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_LAST  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    coord_t h_cnt, v_cnt;
    logic   frame_wrap;

    vga_pixel_counter #(
        .CLK_DIV (CLK_DIV),
        .H_TOT   (H_TOT),
        .V_TOT   (V_TOT)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .pix_tick   (pix_tick),
        .frame_wrap (frame_wrap)
    );

    assign pat.x = h_cnt;
    assign pat.y = v_cnt;

    // Raw decode of the coordinate currently on x/y.
    logic active, hs_raw, vs_raw;
    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = in_window(h_cnt, HS_FIRST, HS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs_raw = in_window(v_cnt, VS_FIRST, VS_LAST) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

    // Colour channels: index 0 = red, 1 = green, 2 = blue.
    logic [2:0][COLOR_W-1:0] color_in;
    logic [2:0][COLOR_W-1:0] color_out;
    assign color_in = {pat.blue, pat.green, pat.red};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            color_t chan_reg;
            // Pattern colour outside the visible area is discarded, not passed on.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chan_reg <= '0;
                end else if (pix_tick) begin
                    chan_reg <= active ? color_in[gi] : '0;
                end
            end
            assign color_out[gi] = chan_reg;
        end
    endgenerate

    assign vga_r = color_out[0];
    assign vga_g = color_out[1];
    assign vga_b = color_out[2];

    logic hsync_reg, vsync_reg, video_on_reg, frame_start_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg       <= ~SYNC_ACTIVE;
            vsync_reg       <= ~SYNC_ACTIVE;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            // Updated every clk so the pulse lasts exactly one system clock.
            frame_start_reg <= frame_wrap;
            if (pix_tick) begin
                hsync_reg    <= hs_raw;
                vsync_reg    <= vs_raw;
                video_on_reg <= active;
            end
        end
    end

    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign frame_start = frame_start_reg;

endmodule
